// File: rtl/fixed_relu_backward.sv
// Backward ReLU: buffers a per-element "input was positive" mask from the forward stream and gates the gradient stream with it.
// Latency: gradient accept in cycle N -> grad_out_0_valid in N+1; 1 beat/cycle per stream.
// Backpressure: forward stalls when the mask buffer is full; gradient stalls when empty or the output register is held.
module fixed_relu_backward #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int GRAD_PRECISION_0            = 16,
  parameter int MASK_DEPTH                  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]    data_in_0 [DATA_IN_0_PARALLELISM_DIM_0-1:0],
  input  logic                                data_in_0_valid,
  output logic                                data_in_0_ready,
  input  logic [GRAD_PRECISION_0-1:0]         grad_in_0 [DATA_IN_0_PARALLELISM_DIM_0-1:0],
  input  logic                                grad_in_0_valid,
  output logic                                grad_in_0_ready,
  output logic [GRAD_PRECISION_0-1:0]         grad_out_0 [DATA_IN_0_PARALLELISM_DIM_0-1:0],
  output logic                                grad_out_0_valid,
  input  logic                                grad_out_0_ready,
  output logic [$clog2(MASK_DEPTH):0]         mask_count
);

  localparam int P  = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int G  = GRAD_PRECISION_0;
  localparam int AW = $clog2(MASK_DEPTH);
  localparam int CW = AW + 1;

  // Pointers wrap by natural overflow, so the depth must be a power of two.
  if ((MASK_DEPTH < 2) || ((MASK_DEPTH & (MASK_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("MASK_DEPTH must be a power of two >= 2");
  end
  if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_frac
    $error("DATA_IN_0_PRECISION_1 exceeds DATA_IN_0_PRECISION_0");
  end

  logic [P-1:0]  mask_mem_q [MASK_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_vld_q, out_vld_d;
  logic [G-1:0]  out_dat_q [P-1:0];
  logic [G-1:0]  out_dat_d [P-1:0];
  logic [P-1:0]  mask_in;
  logic [P-1:0]  mask_rd;
  logic          push;
  logic          pop;

  // Strictly positive: sign bit clear and not zero.
  always_comb begin
    mask_in = '0;
    for (int i = 0; i < P; i++) begin
      mask_in[i] = !data_in_0[i][W-1] && (data_in_0[i] != '0);
    end
  end

  assign data_in_0_ready = (count_q < CW'(MASK_DEPTH));
  assign grad_in_0_ready = (count_q != '0) && (!out_vld_q || grad_out_0_ready);
  assign push            = data_in_0_valid && data_in_0_ready;
  assign pop             = grad_in_0_valid && grad_in_0_ready;
  assign mask_rd         = mask_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      out_vld_d = 1'b1;
      for (int i = 0; i < P; i++) begin
        out_dat_d[i] = mask_rd[i] ? grad_in_0[i] : '0;
      end
    end else if (grad_out_0_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      for (int i = 0; i < P; i++) begin
        out_dat_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  // Mask storage needs no reset; the count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem_q[wr_ptr_q] <= mask_in;
    end
  end

  assign grad_out_0       = out_dat_q;
  assign grad_out_0_valid = out_vld_q;
  assign mask_count       = count_q;

endmodule
